// File: rtl/ft6_stream_packer.sv
// Buffers 64-bit ADC words in a FIFO and streams each one to an FT601 bus as two 32-bit beats,
// low half first. Words that arrive while the FIFO is full are dropped, counted and flagged.
module ft6_stream_packer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          ft6_clk,
  input  logic          rst,
  input  logic [63:0]   in_data,
  input  logic          in_valid,
  input  logic          ft6_txe_n,
  output logic [31:0]   ft6_data,
  output logic [3:0]    ft6_be,
  output logic          ft6_wr_n,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   drop_cnt,
  output logic          overflow
);

  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_drop_cnt;
  logic          r_overflow;
  logic [1:0]    r_state;
  logic [31:0]   r_hold_hi;
  logic [31:0]   r_data;
  logic [3:0]    r_be;
  logic          r_wr_n;

  logic [1:0]    w_state_nxt;
  logic [31:0]   w_hold_nxt;
  logic [31:0]   w_data_nxt;
  logic [3:0]    w_be_nxt;
  logic          w_wr_n_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic [63:0]   w_head;

  assign w_head   = r_mem[r_rptr];
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_accept = ~r_wr_n & ~ft6_txe_n;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign w_push   = in_valid & (~w_full | w_pop);
  assign w_drop   = in_valid & ~w_push;

  // Next-state and next-output logic for the bus side.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_hi;
    w_data_nxt  = r_data;
    w_wr_n_nxt  = r_wr_n;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !ft6_txe_n) begin
          w_pop       = 1'b1;
          w_hold_nxt  = w_head[63:32];
          w_data_nxt  = w_head[31:0];
          w_wr_n_nxt  = 1'b0;
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_accept) begin
          w_data_nxt  = r_hold_hi;
          w_state_nxt = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_accept) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_hold_nxt  = w_head[63:32];
            w_data_nxt  = w_head[31:0];
            w_state_nxt = ST_LOW;
          end else begin
            w_wr_n_nxt  = 1'b1;
            w_data_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_wr_n_nxt  = 1'b1;
        w_data_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_be_nxt = w_wr_n_nxt ? 4'h0 : 4'hF;
  end

  always_ff @(posedge ft6_clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hold_hi <= '0;
      r_data    <= '0;
      r_be      <= 4'h0;
      r_wr_n    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_hold_hi <= w_hold_nxt;
      r_data    <= w_data_nxt;
      r_be      <= w_be_nxt;
      r_wr_n    <= w_wr_n_nxt;
    end
  end

  // FIFO pointers, occupancy and drop accounting.
  always_ff @(posedge ft6_clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge ft6_clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  assign ft6_data   = r_data;
  assign ft6_be     = r_be;
  assign ft6_wr_n   = r_wr_n;
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop_cnt;
  assign overflow   = r_overflow;

endmodule
